output_fetch_serializer: RTL and testbench

- Parametrised successor to the output-pipeline memory fetch stage.
- Reads a frame of wide words from output memory, one word at a time from a selectable bank.
- Serialises each word into ELEM_W-bit elements under a valid/ready handshake, so the downstream writer can stall it.
- Signals frame completion with a done pulse after a programmable drain delay. Supports abort mid-frame.

---
 rtl/output_pipe_pkg.sv | 37 +++
 rtl/output_elem_select.sv | 36 +++
 rtl/output_fetch_serializer.sv | 142 ++++++++++++++
 tb/tb_output_fetch_serializer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/output_pipe_pkg.sv
// Shared types and elaboration helpers for the output fetch/serialise pipeline.
// Sizes counters and vets parameter combinations at elaboration time.
package output_pipe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        DRAIN,
        DONE
    } state_t;

    function automatic int elems(input int bus_w, input int elem_w);
        return bus_w / elem_w;
    endfunction

    // Width of a counter that must hold 0..n-1 (never narrower than 1 bit).
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(
        input int bus_w,
        input int elem_w,
        input int addr_w,
        input int out_w,
        input int frame_words,
        input int done_delay
    );
        return (elem_w > 0) && (bus_w >= elem_w) && (bus_w % elem_w == 0)
            && (addr_w >= 2) && (addr_w <= 31) && (out_w >= elem_w + 1)
            && (frame_words >= 1) && (frame_words <= (1 << (addr_w - 1)))
            && (done_delay >= 0);
    endfunction

endpackage

// File: rtl/output_elem_select.sv
// Element mux: picks element idx out of a latched bus word and
// packs it as {bank, zero padding, element}.
module output_elem_select
    import output_pipe_pkg::*;
#(
    parameter int BUS_W  = 128,
    parameter int ELEM_W = 8,
    parameter int OUT_W  = 16,
    parameter int IDX_W  = 4
) (
    input  logic [BUS_W-1:0] data,
    input  logic [IDX_W-1:0] idx,
    input  logic             bank,
    output logic [OUT_W-1:0] data_out
);

    localparam int ELEMS = elems(BUS_W, ELEM_W);

    logic [ELEM_W-1:0] elem;

    always_comb begin
        elem = '0;
        for (int k = 0; k < ELEMS; k++) begin
            if (idx == IDX_W'(k)) begin
                elem = data[k*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        data_out = '0;
        data_out[ELEM_W-1:0] = elem;
        data_out[OUT_W-1] = bank;
    end

endmodule

// File: rtl/output_fetch_serializer.sv
// Fetches a frame of wide words from a selectable bank and streams them out
// element by element under valid/ready, ending with a delayed done pulse.
module output_fetch_serializer
    import output_pipe_pkg::*;
#(
    parameter int BUS_W       = 128,
    parameter int ELEM_W      = 8,
    parameter int ADDR_W      = 16,
    parameter int OUT_W       = 16,
    parameter int FRAME_WORDS = 19200,
    parameter int DONE_DELAY  = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              base_select,
    input  logic [BUS_W-1:0]  ReadBus,
    output logic              read_en,
    output logic [ADDR_W-1:0] ReadAddress,
    output logic [OUT_W-1:0]  DataOut,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int ELEMS  = elems(BUS_W, ELEM_W);
    localparam int IDX_W  = cnt_w(ELEMS);
    localparam int WORD_W = cnt_w(FRAME_WORDS);
    localparam int DLY_W  = cnt_w(DONE_DELAY);

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(ELEMS - 1);
    localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(FRAME_WORDS - 1);
    localparam logic [DLY_W-1:0]  DLY_LAST  =
        DLY_W'((DONE_DELAY > 0) ? DONE_DELAY - 1 : 0);

    if (!params_ok(BUS_W, ELEM_W, ADDR_W, OUT_W, FRAME_WORDS, DONE_DELAY))
    begin : g_bad_params
        $error("output_fetch_serializer: illegal parameter combination");
    end

    state_t            state;
    state_t            next_state;
    logic              bank;
    logic [BUS_W-1:0]  data_reg;
    logic [IDX_W-1:0]  elem_idx;
    logic [WORD_W-1:0] word_cnt;
    logic [DLY_W-1:0]  dly_cnt;
    logic              xfer;
    logic              accept;

    assign xfer   = (state == SHIFT) && out_ready;
    assign accept = (state == IDLE) && start && !abort;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        read_en    = 1'b0;
        out_valid  = 1'b0;
        busy       = (state != IDLE);
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) next_state = FETCH;
            end
            FETCH: begin
                read_en    = 1'b1;
                next_state = LOAD;
            end
            LOAD: next_state = SHIFT;
            SHIFT: begin
                out_valid = 1'b1;
                if (xfer && elem_idx == IDX_LAST) begin
                    if (word_cnt != WORD_LAST) next_state = FETCH;
                    else if (DONE_DELAY == 0)  next_state = DONE;
                    else                       next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (dly_cnt == DLY_LAST) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (abort) next_state = IDLE;
    end

    // Datapath freezes on abort so DataOut keeps its last value in IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            bank        <= 1'b0;
            ReadAddress <= '0;
            data_reg    <= '0;
            elem_idx    <= '0;
            word_cnt    <= '0;
            dly_cnt     <= '0;
        end else if (!abort) begin
            dly_cnt <= (state == DRAIN) ? dly_cnt + 1'b1 : '0;
            if (accept) begin
                bank        <= base_select;
                ReadAddress <= {base_select, {(ADDR_W-1){1'b0}}};
                word_cnt    <= '0;
            end
            if (state == LOAD) begin
                data_reg <= ReadBus;
                elem_idx <= '0;
            end
            if (xfer) begin
                if (elem_idx != IDX_LAST) begin
                    elem_idx <= elem_idx + 1'b1;
                end else if (word_cnt != WORD_LAST) begin
                    word_cnt <= word_cnt + 1'b1;
                    ReadAddress[ADDR_W-2:0] <= ReadAddress[ADDR_W-2:0] + 1'b1;
                end
            end
        end
    end

    output_elem_select #(
        .BUS_W (BUS_W),
        .ELEM_W(ELEM_W),
        .OUT_W (OUT_W),
        .IDX_W (IDX_W)
    ) u_elem_select (
        .data    (data_reg),
        .idx     (elem_idx),
        .bank    (bank),
        .data_out(DataOut)
    );

endmodule

// File: tb/tb_output_fetch_serializer.sv
// Directed bench for output_fetch_serializer with element/address scoreboards.
module tb_output_fetch_serializer;

    localparam logic [31:0] WORD = 32'h44332211;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // DUT A: FRAME_WORDS=4, DONE_DELAY=3
    logic        a_start = 1'b0;
    logic        a_abort = 1'b0;
    logic        a_sel = 1'b0;
    logic [31:0] a_bus = 32'hDEADBEEF;
    logic        a_rd;
    logic [15:0] a_addr;
    logic [15:0] a_dout;
    logic        a_valid;
    logic        a_ready = 1'b1;
    logic        a_busy;
    logic        a_done;

    // DUT B: FRAME_WORDS=1, DONE_DELAY=0
    logic        b_start = 1'b0;
    logic [31:0] b_bus = 32'hDEADBEEF;
    logic        b_rd;
    logic [15:0] b_addr;
    logic [15:0] b_dout;
    logic        b_valid;
    logic        b_busy;
    logic        b_done;

    output_fetch_serializer #(
        .BUS_W(32), .ELEM_W(8), .ADDR_W(16), .OUT_W(16),
        .FRAME_WORDS(4), .DONE_DELAY(3)
    ) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .abort(a_abort),
        .base_select(a_sel), .ReadBus(a_bus), .read_en(a_rd),
        .ReadAddress(a_addr), .DataOut(a_dout), .out_valid(a_valid),
        .out_ready(a_ready), .busy(a_busy), .done(a_done)
    );

    output_fetch_serializer #(
        .BUS_W(32), .ELEM_W(8), .ADDR_W(16), .OUT_W(16),
        .FRAME_WORDS(1), .DONE_DELAY(0)
    ) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .abort(1'b0),
        .base_select(1'b0), .ReadBus(b_bus), .read_en(b_rd),
        .ReadAddress(b_addr), .DataOut(b_dout), .out_valid(b_valid),
        .out_ready(1'b1), .busy(b_busy), .done(b_done)
    );

    // Memory model: data valid exactly one cycle after read_en.
    always @(posedge clock) begin
        a_bus <= a_rd ? WORD : 32'hDEADBEEF;
        b_bus <= b_rd ? WORD : 32'hDEADBEEF;
    end

    logic [15:0] a_dq[$];
    logic [15:0] a_aq[$];
    logic [15:0] b_dq[$];
    logic [15:0] a_ed, a_ea, b_ed;
    int a_xfers, a_reads, a_dones, a_last_xfer, a_done_cyc;
    int a_first_rd, a_first_xfer, a_start_cyc;
    int b_xfers, b_reads, b_dones, b_last_xfer, b_done_cyc;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (a_valid && a_ready) begin
                if (a_dq.size() == 0) begin
                    check("a_extra_elem", 32'(a_dout), 32'hFFFFFFFF);
                end else begin
                    a_ed = a_dq.pop_front();
                    check("a_elem", 32'(a_dout), 32'(a_ed));
                end
                a_xfers++;
                a_last_xfer = cyc;
                if (a_first_xfer < 0) a_first_xfer = cyc;
            end
            if (a_rd) begin
                if (a_aq.size() == 0) begin
                    check("a_extra_read", 32'(a_addr), 32'hFFFFFFFF);
                end else begin
                    a_ea = a_aq.pop_front();
                    check("a_addr", 32'(a_addr), 32'(a_ea));
                end
                a_reads++;
                if (a_first_rd < 0) a_first_rd = cyc;
            end
            if (a_done) begin
                a_dones++;
                a_done_cyc = cyc;
            end
            if (b_valid) begin
                if (b_dq.size() == 0) begin
                    check("b_extra_elem", 32'(b_dout), 32'hFFFFFFFF);
                end else begin
                    b_ed = b_dq.pop_front();
                    check("b_elem", 32'(b_dout), 32'(b_ed));
                end
                b_xfers++;
                b_last_xfer = cyc;
            end
            if (b_rd) b_reads++;
            if (b_done) begin
                b_dones++;
                b_done_cyc = cyc;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_frame(input logic bank, input int words,
                              input bit to_b);
        logic [31:0] wv;
        wv = WORD;
        for (int w = 0; w < words; w++) begin
            if (!to_b) a_aq.push_back({bank, 15'(w)});
            for (int k = 0; k < 4; k++) begin
                if (to_b) b_dq.push_back({bank, 7'b0, wv[k*8 +: 8]});
                else      a_dq.push_back({bank, 7'b0, wv[k*8 +: 8]});
            end
        end
    endtask

    task automatic start_a(input logic bank);
        push_frame(bank, 4, 1'b0);
        a_xfers = 0;
        a_reads = 0;
        a_first_rd = -1;
        a_first_xfer = -1;
        a_sel = bank;
        a_start = 1'b1;
        a_start_cyc = cyc;
        step();
        a_start = 1'b0;
    endtask

    task automatic wait_done_a(input string tag);
        int prev;
        int n;
        prev = a_dones;
        n = 0;
        while (a_dones == prev && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(a_dones - prev), 32'd1);
    endtask

    task automatic wait_xfers_a(input int target, input string tag);
        int n;
        n = 0;
        while (!(a_valid && a_xfers == target) && n < 300) begin
            step();
            n++;
        end
        check(tag, 32'(a_xfers), 32'(target));
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, "_addr"}, 32'(a_addr), 32'd0);
        check({tag, "_rd"}, 32'(a_rd), 32'd0);
        check({tag, "_dout"}, 32'(a_dout), 32'd0);
        check({tag, "_valid"}, 32'(a_valid), 32'd0);
        check({tag, "_busy"}, 32'(a_busy), 32'd0);
        check({tag, "_done"}, 32'(a_done), 32'd0);
    endtask

    initial begin
        int prev;
        int n;
        a_xfers = 0; a_reads = 0; a_dones = 0;
        a_last_xfer = 0; a_done_cyc = 0;
        a_first_rd = -1; a_first_xfer = -1; a_start_cyc = 0;
        b_xfers = 0; b_reads = 0; b_dones = 0;
        b_last_xfer = 0; b_done_cyc = 0;

        // reset state
        repeat (3) step();
        check_reset_a("rst");
        check("rst_b_busy", 32'(b_busy), 32'd0);
        reset = 1'b0;
        step();

        // basic frame, bank 0
        start_a(1'b0);
        wait_done_a("basic_done");
        check("basic_xfers", 32'(a_xfers), 32'd16);
        check("basic_reads", 32'(a_reads), 32'd4);
        check("basic_done_gap", 32'(a_done_cyc - a_last_xfer), 32'd4);
        check("basic_lat_rd", 32'(a_first_rd - a_start_cyc), 32'd1);
        check("basic_lat_valid", 32'(a_first_xfer - a_start_cyc), 32'd3);
        check("basic_q_empty", 32'(a_dq.size() + a_aq.size()), 32'd0);
        check("basic_idle", 32'(a_busy), 32'd0);

        // bank 1 with base_select toggling mid-frame
        start_a(1'b1);
        prev = a_dones;
        n = 0;
        while (a_dones == prev && n < 300) begin
            a_sel = ~a_sel;
            step();
            n++;
        end
        check("bank1_done", 32'(a_dones - prev), 32'd1);
        check("bank1_xfers", 32'(a_xfers), 32'd16);
        check("bank1_q_empty", 32'(a_dq.size() + a_aq.size()), 32'd0);
        a_sel = 1'b0;
        step();

        // backpressure on element 2 of word 1
        start_a(1'b0);
        wait_xfers_a(6, "bp_reach");
        a_ready = 1'b0;
        repeat (5) begin
            check("bp_hold_dout", 32'(a_dout), 32'h0033);
            check("bp_hold_valid", 32'(a_valid), 32'd1);
            check("bp_no_read", 32'(a_rd), 32'd0);
            check("bp_hold_addr", 32'(a_addr), 32'd1);
            step();
        end
        a_ready = 1'b1;
        wait_done_a("bp_done");
        check("bp_xfers", 32'(a_xfers), 32'd16);
        check("bp_reads", 32'(a_reads), 32'd4);
        check("bp_q_empty", 32'(a_dq.size() + a_aq.size()), 32'd0);
        step();

        // abort during word 2
        start_a(1'b0);
        wait_xfers_a(9, "abort_reach");
        prev = a_dones;
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        check("abort_busy", 32'(a_busy), 32'd0);
        check("abort_valid", 32'(a_valid), 32'd0);
        check("abort_rd", 32'(a_rd), 32'd0);
        repeat (20) step();
        check("abort_no_done", 32'(a_dones - prev), 32'd0);
        a_dq.delete();
        a_aq.delete();
        start_a(1'b0);
        wait_done_a("restart_done");
        check("restart_xfers", 32'(a_xfers), 32'd16);
        check("restart_q_empty", 32'(a_dq.size() + a_aq.size()), 32'd0);
        step();

        // reset at the 7th transfer
        start_a(1'b0);
        wait_xfers_a(6, "rstmid_reach");
        prev = a_dones;
        reset = 1'b1;
        step();
        check_reset_a("rstmid");
        reset = 1'b0;
        repeat (20) step();
        check("rstmid_no_done", 32'(a_dones - prev), 32'd0);
        check("rstmid_idle", 32'(a_busy), 32'd0);
        a_dq.delete();
        a_aq.delete();

        // DONE_DELAY=0, one word, start held through busy and DONE
        push_frame(1'b0, 1, 1'b1);
        b_start = 1'b1;
        n = 0;
        step();
        while (!b_done && n < 100) begin
            step();
            n++;
        end
        step();
        b_start = 1'b0;
        repeat (20) step();
        check("b_xfers", 32'(b_xfers), 32'd4);
        check("b_reads", 32'(b_reads), 32'd1);
        check("b_dones", 32'(b_dones), 32'd1);
        check("b_done_gap", 32'(b_done_cyc - b_last_xfer), 32'd1);
        check("b_idle", 32'(b_busy), 32'd0);
        check("b_q_empty", 32'(b_dq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
